// File: rtl/nand_unit_pkg.sv
// rtl/nand_unit_pkg.sv - shared opcode/state types and width helper for the NAND unit arbiter
package nand_unit_pkg;

   typedef enum logic [1:0] {
      OP_NAND = 2'b00,
      OP_NOT  = 2'b01,
      OP_AND  = 2'b10,
      OP_OR   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nand_logic_unit.sv
// rtl/nand_logic_unit.sv - combinational NOT/AND/OR/NAND unit built only from two-input NAND terms
module nand_logic_unit
   import nand_unit_pkg::*;
#(
   parameter int BIT_LEN = 1
) (
   input  logic [1:0]         op,
   input  logic [BIT_LEN-1:0] a,
   input  logic [BIT_LEN-1:0] b,
   output logic [BIT_LEN-1:0] y
);

   logic [BIT_LEN-1:0] nand_ab;
   logic [BIT_LEN-1:0] nand_aa;
   logic [BIT_LEN-1:0] nand_bb;
   logic [BIT_LEN-1:0] and_ab;
   logic [BIT_LEN-1:0] or_ab;

   // First level: every term is a NAND of two signals; second level reuses them.
   assign nand_ab = ~(a & b);
   assign nand_aa = ~(a & a);
   assign nand_bb = ~(b & b);
   assign and_ab  = ~(nand_ab & nand_ab);
   assign or_ab   = ~(nand_aa & nand_bb);

   always_comb begin
      y = nand_ab;
      case (op_e'(op))
         OP_NAND: y = nand_ab;
         OP_NOT:  y = nand_aa;
         OP_AND:  y = and_ab;
         OP_OR:   y = or_ab;
         default: y = nand_ab;
      endcase
   end

endmodule

// File: rtl/nand_unit_arbiter.sv
// rtl/nand_unit_arbiter.sv - round-robin sharing of one NAND logic unit with registered valid/ready response
module nand_unit_arbiter
   import nand_unit_pkg::*;
#(
   parameter  int BIT_LEN     = 1,
   parameter  int N_REQ       = 4,
   parameter  int EXEC_CYCLES = 1,
   localparam int ID_W        = id_width(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [2*N_REQ-1:0]         req_op,
   input  logic [BIT_LEN*N_REQ-1:0]   req_a,
   input  logic [BIT_LEN*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]           gnt,
   output logic                       resp_valid,
   output logic [ID_W-1:0]            resp_id,
   output logic [BIT_LEN-1:0]         resp_data,
   input  logic                       resp_ready
);

   localparam int              CNT_W    = id_width(EXEC_CYCLES);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ID_W-1:0]      win_q, win_d;
   logic [1:0]           op_q, op_d;
   logic [BIT_LEN-1:0]   a_q, a_d;
   logic [BIT_LEN-1:0]   b_q, b_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]      resp_id_q, resp_id_d;
   logic [BIT_LEN-1:0]   resp_data_q, resp_data_d;

   logic [N_REQ-1:0]     req_rot;
   logic [ID_W:0]        cand;
   logic [ID_W:0]        ptr_inc;
   logic                 win_found;
   logic [ID_W-1:0]      win_idx;
   logic [1:0]           sel_op;
   logic [BIT_LEN-1:0]   sel_a;
   logic [BIT_LEN-1:0]   sel_b;
   logic [BIT_LEN-1:0]   unit_y;

   // Rotate so bit 0 is the requester at rr_ptr; the first set bit wins.
   assign req_rot = N_REQ'({req, req} >> rr_ptr_q);

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!win_found && req_rot[k]) begin
            win_found = 1'b1;
            win_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_idx == ID_W'(k)) begin
            sel_op = req_op[2*k +: 2];
            sel_a  = req_a[BIT_LEN*k +: BIT_LEN];
            sel_b  = req_b[BIT_LEN*k +: BIT_LEN];
         end
      end
   end

   assign ptr_inc = {1'b0, win_idx} + (ID_W+1)'(1);

   nand_logic_unit #(
      .BIT_LEN (BIT_LEN)
   ) u_logic (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y)
   );

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      win_d        = win_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      gnt          = '0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               gnt      = N_REQ'(1) << win_idx;
               win_d    = win_idx;
               op_d     = sel_op;
               a_d      = sel_a;
               b_d      = sel_b;
               rr_ptr_d = (ptr_inc >= (ID_W+1)'(N_REQ)) ? '0 : ptr_inc[ID_W-1:0];
               cnt_d    = CNT_INIT;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               resp_data_d  = unit_y;
               resp_id_d    = win_q;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_valid_q && resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         gnt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         win_q        <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         win_q        <= win_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// tb/tb_nand_unit_arbiter.sv - directed and randomized checks of nand_unit_arbiter against a transaction model
module tb_nand_unit_arbiter;

   localparam int BL = 4;
   localparam int NR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0 drives the EXEC_CYCLES=1 instance, index 1 the EXEC_CYCLES=3 instance.
   logic [1:0]                rst_s;
   logic [1:0][NR-1:0]        req_s;
   logic [1:0][2*NR-1:0]      op_s;
   logic [1:0][BL*NR-1:0]     a_s;
   logic [1:0][BL*NR-1:0]     b_s;
   logic [1:0]                ready_s;
   logic [1:0][NR-1:0]        gnt_s;
   logic [1:0]                vld_s;
   logic [1:0][1:0]           id_s;
   logic [1:0][BL-1:0]        dat_s;

   nand_unit_arbiter #(.BIT_LEN(BL), .N_REQ(NR), .EXEC_CYCLES(1)) u_dut_e1 (
      .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .req_op(op_s[0]), .req_a(a_s[0]), .req_b(b_s[0]),
      .gnt(gnt_s[0]), .resp_valid(vld_s[0]), .resp_id(id_s[0]), .resp_data(dat_s[0]), .resp_ready(ready_s[0])
   );

   nand_unit_arbiter #(.BIT_LEN(BL), .N_REQ(NR), .EXEC_CYCLES(3)) u_dut_e3 (
      .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .req_op(op_s[1]), .req_a(a_s[1]), .req_b(b_s[1]),
      .gnt(gnt_s[1]), .resp_valid(vld_s[1]), .resp_id(id_s[1]), .resp_data(dat_s[1]), .resp_ready(ready_s[1])
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   function automatic logic [BL-1:0] ref_op(input logic [1:0] op, input logic [BL-1:0] a, input logic [BL-1:0] b);
      case (op)
         2'b00:   return ~(a & b);
         2'b01:   return ~a;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Transaction model: an owner plus the cycle it was granted; the result is due EXEC+1 cycles later.
   int             m_owner [2];
   int             m_gtime [2];
   int             m_ptr   [2];
   logic [BL-1:0]  m_res   [2];
   logic           m_prev_rst [2];
   logic           m_gflag [2];
   int             m_gwho  [2];
   int             m_wait  [2][NR];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int            e;
         int            w;
         int            idx;
         logic [NR-1:0] eg;
         e = (d == 0) ? 1 : 3;
         if (m_prev_rst[d]) begin
            check_val("rst_vld", vld_s[d], 0);
            check_val("rst_id", id_s[d], 0);
            check_val("rst_data", dat_s[d], 0);
         end
         m_prev_rst[d] = rst_s[d];
         m_gflag[d] = 1'b0;
         if (rst_s[d]) begin
            check_val("rst_gnt", gnt_s[d], 0);
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            for (int i = 0; i < NR; i++) m_wait[d][i] = 0;
         end else begin
            for (int i = 0; i < NR; i++) if (!req_s[d][i]) m_wait[d][i] = 0;
            if (m_owner[d] < 0) begin
               w  = -1;
               eg = '0;
               for (int k = 0; k < NR; k++) begin
                  idx = (m_ptr[d] + k) % NR;
                  if (w < 0 && req_s[d][idx]) w = idx;
               end
               if (w >= 0) begin
                  eg[w] = 1'b1;
                  check_val("fair", m_wait[d][w] < NR, 1);
                  for (int i = 0; i < NR; i++) if (i != w && req_s[d][i]) m_wait[d][i]++;
                  m_wait[d][w] = 0;
                  m_owner[d] = w;
                  m_gtime[d] = cyc;
                  m_res[d]   = ref_op(op_s[d][2*w +: 2], a_s[d][BL*w +: BL], b_s[d][BL*w +: BL]);
                  m_ptr[d]   = (w + 1) % NR;
                  m_gflag[d] = 1'b1;
                  m_gwho[d]  = w;
               end
               check_val("gnt", gnt_s[d], eg);
               check_val("idle_vld", vld_s[d], 0);
            end else begin
               check_val("busy_gnt", gnt_s[d], 0);
               if (cyc >= m_gtime[d] + e + 1) begin
                  check_val("vld", vld_s[d], 1);
                  check_val("id", id_s[d], m_owner[d]);
                  check_val("data", dat_s[d], m_res[d]);
                  if (ready_s[d]) m_owner[d] = -1;
               end else begin
                  check_val("exec_vld", vld_s[d], 0);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int d, input int i, input logic [1:0] op, input logic [BL-1:0] a, input logic [BL-1:0] b);
      req_s[d][i]          = 1'b1;
      op_s[d][2*i +: 2]    = op;
      a_s[d][BL*i +: BL]   = a;
      b_s[d][BL*i +: BL]   = b;
   endtask

   task automatic reset_dut(input int d);
      rst_s[d] = 1'b1;
      req_s[d] = '0;
      step();
      step();
      rst_s[d] = 1'b0;
   endtask

   task automatic wait_gnt(input int d, output int n);
      n = 0;
      @(negedge clk);
      while (gnt_s[d] == '0 && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      if (n >= 20) check_val("gnt_timeout", 0, 1);
   endtask

   task automatic wait_vld(input int d, output int n);
      n = 0;
      @(negedge clk);
      while (!vld_s[d] && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      if (n >= 20) check_val("vld_timeout", 0, 1);
   endtask

   logic [BL-1:0] exp_ops [4];
   int n;

   initial begin
      rst_s = '1; req_s = '0; op_s = '0; a_s = '0; b_s = '0; ready_s = '1;
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1; m_gtime[d] = 0; m_ptr[d] = 0; m_res[d] = '0;
         m_prev_rst[d] = 1'b0; m_gflag[d] = 1'b0; m_gwho[d] = 0;
         for (int i = 0; i < NR; i++) m_wait[d][i] = 0;
      end
      exp_ops = '{4'b1101, 4'b1001, 4'b0010, 4'b0111};
      step();
      step();
      rst_s = '0;

      // single AND request, EXEC_CYCLES=1
      set_req(0, 2, 2'b10, 4'b1100, 4'b1010);
      wait_gnt(0, n);
      check_val("t1_gnt", gnt_s[0], 4'b0100);
      step();
      req_s[0][2] = 1'b0;
      @(negedge clk);
      check_val("t1_vld_early", vld_s[0], 0);
      step();
      @(negedge clk);
      check_val("t1_vld", vld_s[0], 1);
      check_val("t1_id", id_s[0], 2);
      check_val("t1_data", dat_s[0], 4'b1000);
      step();

      // all requesters held: rotation order and spacing
      reset_dut(0);
      for (int i = 0; i < NR; i++) set_req(0, i, 2'(i), 4'($urandom), 4'($urandom));
      for (int g = 0; g < 5; g++) begin
         wait_gnt(0, n);
         check_val("t2_gnt", gnt_s[0], 32'(1) << (g % NR));
         if (g > 0) check_val("t2_space", n + 1, 3);
         step();
      end
      req_s[0] = '0;
      repeat (4) step();

      // each opcode on fixed operands
      for (int op = 0; op < 4; op++) begin
         set_req(0, 1, 2'(op), 4'b0110, 4'b0011);
         wait_gnt(0, n);
         step();
         req_s[0][1] = 1'b0;
         wait_vld(0, n);
         check_val("t3_data", dat_s[0], exp_ops[op]);
         step();
      end

      // backpressure stall
      reset_dut(0);
      ready_s[0] = 1'b0;
      set_req(0, 0, 2'b00, 4'b0110, 4'b0011);
      wait_gnt(0, n);
      check_val("t4_gnt", gnt_s[0], 4'b0001);
      step();
      req_s[0][0] = 1'b0;
      set_req(0, 1, 2'b10, 4'b0110, 4'b0011);
      wait_vld(0, n);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            step();
            @(negedge clk);
         end
         check_val("t4_vld", vld_s[0], 1);
         check_val("t4_id", id_s[0], 0);
         check_val("t4_data", dat_s[0], 4'b1101);
         check_val("t4_stall_gnt", gnt_s[0], 0);
      end
      step();
      ready_s[0] = 1'b1;
      @(negedge clk);
      check_val("t4_hs_gnt", gnt_s[0], 0);
      step();
      @(negedge clk);
      check_val("t4_next_gnt", gnt_s[0], 4'b0010);
      step();
      req_s[0][1] = 1'b0;
      wait_vld(0, n);
      check_val("t4_next_data", dat_s[0], 4'b0010);
      step();

      // EXEC_CYCLES=3 latency and operand isolation
      reset_dut(1);
      set_req(1, 3, 2'b11, 4'b0101, 4'b0010);
      wait_gnt(1, n);
      check_val("t5_gnt", gnt_s[1], 4'b1000);
      step();
      req_s[1][3] = 1'b0;
      a_s[1][BL*3 +: BL] = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("t5_wait_vld", vld_s[1], 0);
         step();
      end
      @(negedge clk);
      check_val("t5_vld", vld_s[1], 1);
      check_val("t5_id", id_s[1], 3);
      check_val("t5_data", dat_s[1], 4'b0111);
      step();

      // reset in the middle of EXEC
      set_req(1, 2, 2'b00, 4'b1111, 4'b0000);
      wait_gnt(1, n);
      check_val("t6_first_gnt", gnt_s[1], 4'b0100);
      step();
      req_s[1][2] = 1'b0;
      rst_s[1] = 1'b1;
      set_req(1, 0, 2'b01, 4'b1010, 4'b0000);
      set_req(1, 3, 2'b10, 4'b1110, 4'b0111);
      @(negedge clk);
      check_val("t6_rst_gnt", gnt_s[1], 0);
      step();
      @(negedge clk);
      check_val("t6_vld", vld_s[1], 0);
      check_val("t6_gnt", gnt_s[1], 0);
      step();
      rst_s[1] = 1'b0;
      @(negedge clk);
      check_val("t6_gnt_after", gnt_s[1], 4'b0001);
      step();
      req_s[1][0] = 1'b0;

      // randomized traffic with backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NR; i++) begin
               if (m_gflag[d] && m_gwho[d] == i) begin
                  if ($urandom_range(0, 1) == 0) req_s[d][i] = 1'b0;
                  else set_req(d, i, 2'($urandom), 4'($urandom), 4'($urandom));
               end else if (req_s[d][i]) begin
                  if ($urandom_range(0, 15) == 0) req_s[d][i] = 1'b0;
               end else if ($urandom_range(0, 2) == 0) begin
                  set_req(d, i, 2'($urandom), 4'($urandom), 4'($urandom));
               end
            end
            ready_s[d] = ($urandom_range(0, 9) < 7);
            rst_s[d]   = ($urandom_range(0, 199) == 0);
         end
         step();
      end
      req_s = '0; rst_s = '0; ready_s = '1;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
